// File: rtl/mbist_pkg.sv
// Shared types and helpers for the SRAM background generator/checker.
// Holds the FSM encoding, background-mode constants and the pattern function.
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic BG_SOLID   = 1'b0;
  localparam logic BG_CHECKER = 1'b1;

  // One bit of the background; callers replicate it across the word.
  function automatic logic exp_bit(input logic rev, input logic chk, input logic a0);
    return rev ^ ((chk == BG_CHECKER) & a0);
  endfunction

endpackage

// File: rtl/mbist_delay_line.sv
// Aligns {valid, addr, expected} of each issued read with the returning read data.
// RD_LAT stages deep; cleared by reset or by an aborted run.
module mbist_delay_line #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_exp,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_exp
);

  logic              r_vld  [RD_LAT];
  logic [ADDR_W-1:0] r_addr [RD_LAT];
  logic [DATA_W-1:0] r_exp  [RD_LAT];

  always_ff @(posedge clk) begin
    if (i_rst || i_flush) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_exp[i]  <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_addr;
      r_exp[0]  <= i_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_exp[i]  <= r_exp[i-1];
      end
    end
  end

  assign o_vld  = r_vld[RD_LAT-1];
  assign o_addr = r_addr[RD_LAT-1];
  assign o_exp  = r_exp[RD_LAT-1];

endmodule

// File: rtl/blanket_gen.sv
// MBIST background generator/checker: writes a solid or checkerboard background to
// every SRAM address, optionally reads it back and records mismatches.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for en_in; error registers hold last run's result
//  ST_WRITE | one write per cycle, addresses 0..max
//  ST_READ  | one read per cycle, addresses 0..max, compares in flight
//  ST_DRAIN | RD_LAT cycles without enables to retire the last compares
//  ST_DONE  | rst_done high until en_in drops
module blanket_gen
  import mbist_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              rev_in,
  input  logic              chk_in,
  input  logic              verify_in,
  input  logic [DATA_W-1:0] rd_dat_in,
  output logic [DATA_W-1:0] dat_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              w_en_out,
  output logic              r_en_out,
  output logic              busy_out,
  output logic              rst_done,
  output logic              err_out,
  output logic [ADDR_W-1:0] err_addr_out,
  output logic [CNT_W-1:0]  err_cnt_out
);

  state_t      r_state;
  logic        r_rev;
  logic        r_chk;
  logic        r_verify;
  logic [2:0]  r_drain_cnt;

  logic              w_busy_st;
  logic              w_abort;
  logic              w_start;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wr_first;
  logic [DATA_W-1:0] w_wr_nxt;
  logic [DATA_W-1:0] w_rd_exp;
  logic              w_dl_vld;
  logic [ADDR_W-1:0] w_dl_addr;
  logic [DATA_W-1:0] w_dl_exp;
  logic              w_mis;
  logic              w_cnt_max;

  assign w_busy_st  = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign w_abort    = w_busy_st && !en_in;
  assign w_start    = (r_state == ST_IDLE) && en_in;
  assign w_last     = (addr_out == {ADDR_W{1'b1}});
  assign w_addr_nxt = addr_out + ADDR_W'(1);
  assign w_wr_first = {DATA_W{exp_bit(rev_in, chk_in, 1'b0)}};
  assign w_wr_nxt   = {DATA_W{exp_bit(r_rev, r_chk, w_addr_nxt[0])}};
  assign w_rd_exp   = {DATA_W{exp_bit(r_rev, r_chk, addr_out[0])}};
  assign w_mis      = w_dl_vld && (rd_dat_in != w_dl_exp);
  assign w_cnt_max  = (err_cnt_out == {CNT_W{1'b1}});

  mbist_delay_line #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_dly (
    .clk     (clk),
    .i_rst   (rst),
    .i_flush (w_abort),
    .i_vld   (r_en_out),
    .i_addr  (addr_out),
    .i_exp   (w_rd_exp),
    .o_vld   (w_dl_vld),
    .o_addr  (w_dl_addr),
    .o_exp   (w_dl_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rev        <= 1'b0;
      r_chk        <= 1'b0;
      r_verify     <= 1'b0;
      r_drain_cnt  <= '0;
      dat_out      <= '0;
      addr_out     <= '0;
      w_en_out     <= 1'b0;
      r_en_out     <= 1'b0;
      busy_out     <= 1'b0;
      rst_done     <= 1'b0;
      err_out      <= 1'b0;
      err_addr_out <= '0;
      err_cnt_out  <= '0;
    end else begin
      if (w_abort) begin
        r_state  <= ST_IDLE;
        dat_out  <= '0;
        addr_out <= '0;
        w_en_out <= 1'b0;
        r_en_out <= 1'b0;
        busy_out <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (en_in) begin
              r_state  <= ST_WRITE;
              r_rev    <= rev_in;
              r_chk    <= chk_in;
              r_verify <= verify_in;
              addr_out <= '0;
              dat_out  <= w_wr_first;
              w_en_out <= 1'b1;
              busy_out <= 1'b1;
            end
          end
          ST_WRITE: begin
            if (w_last) begin
              w_en_out <= 1'b0;
              dat_out  <= '0;
              addr_out <= '0;
              if (r_verify) begin
                r_state  <= ST_READ;
                r_en_out <= 1'b1;
              end else begin
                r_state  <= ST_DONE;
                busy_out <= 1'b0;
                rst_done <= 1'b1;
              end
            end else begin
              addr_out <= w_addr_nxt;
              dat_out  <= w_wr_nxt;
            end
          end
          ST_READ: begin
            if (w_last) begin
              r_state     <= ST_DRAIN;
              r_en_out    <= 1'b0;
              addr_out    <= '0;
              r_drain_cnt <= 3'(RD_LAT - 1);
            end else begin
              addr_out <= w_addr_nxt;
            end
          end
          ST_DRAIN: begin
            if (r_drain_cnt == 3'd0) begin
              r_state  <= ST_DONE;
              busy_out <= 1'b0;
              rst_done <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt - 3'd1;
            end
          end
          ST_DONE: begin
            // en_in must drop before another run can start.
            if (!en_in) begin
              r_state  <= ST_IDLE;
              rst_done <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_start) begin
        err_out      <= 1'b0;
        err_addr_out <= '0;
        err_cnt_out  <= '0;
      end else if (w_mis && !w_abort) begin
        err_out <= 1'b1;
        if (!err_out) err_addr_out <= w_dl_addr;
        if (!w_cnt_max) err_cnt_out <= err_cnt_out + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_blanket_gen.sv
// Directed bench for blanket_gen: SRAM model with per-address fault masks,
// a second instance with a narrow error counter for saturation.
module tb_blanket_gen;

  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en_in, rev_in, chk_in, verify_in;
  logic [DW-1:0] rd_dat_in, dat_out;
  logic [AW-1:0] addr_out, err_addr_out;
  logic          w_en_out, r_en_out, busy_out, rst_done, err_out;
  logic [7:0]    err_cnt_out;

  logic          en_b;
  logic [DW-1:0] rd_dat_b, dat_b;
  logic [AW-1:0] addr_b, err_addr_b;
  logic          w_en_b, r_en_b, busy_b, done_b, err_b;
  logic [1:0]    err_cnt_b;

  blanket_gen #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .rev_in(rev_in), .chk_in(chk_in),
    .verify_in(verify_in), .rd_dat_in(rd_dat_in), .dat_out(dat_out),
    .addr_out(addr_out), .w_en_out(w_en_out), .r_en_out(r_en_out),
    .busy_out(busy_out), .rst_done(rst_done), .err_out(err_out),
    .err_addr_out(err_addr_out), .err_cnt_out(err_cnt_out)
  );

  blanket_gen #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en_in(en_b), .rev_in(1'b0), .chk_in(1'b0),
    .verify_in(1'b1), .rd_dat_in(rd_dat_b), .dat_out(dat_b),
    .addr_out(addr_b), .w_en_out(w_en_b), .r_en_out(r_en_b),
    .busy_out(busy_b), .rst_done(done_b), .err_out(err_b),
    .err_addr_out(err_addr_b), .err_cnt_out(err_cnt_b)
  );

  // Every read of the saturation instance returns a corrupted word.
  assign rd_dat_b = 4'hF;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] flt [DEPTH];
  logic [DW-1:0] pipe0, pipe1;

  always @(posedge clk) begin
    if (w_en_out) mem[addr_out] <= dat_out;
    pipe0 <= r_en_out ? (mem[addr_out] | flt[addr_out]) : 4'h0;
    pipe1 <= pipe0;
  end
  assign rd_dat_in = pipe1;

  int n_wr = 0, n_wr_bad = 0, n_rd = 0, n_both = 0;
  logic [AW-1:0] exp_wa = '0;

  always @(negedge clk) begin
    if (!busy_out) exp_wa <= '0;
    else if (w_en_out) begin
      n_wr <= n_wr + 1;
      if (addr_out != exp_wa || dat_out != {DW{rev_in ^ (chk_in & addr_out[0])}})
        n_wr_bad <= n_wr_bad + 1;
      exp_wa <= exp_wa + 8'd1;
    end
    if (r_en_out) n_rd <= n_rd + 1;
    if (r_en_out && w_en_out) n_both <= n_both + 1;
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!rst_done && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  function automatic logic [63:0] all_out();
    return {dat_out, addr_out, w_en_out, r_en_out, busy_out, rst_done,
            err_out, err_addr_out, err_cnt_out};
  endfunction

  initial begin
    int cyc, k, w0, wb0, r0;
    rst = 1'b1; en_in = 1'b0; rev_in = 1'b0; chk_in = 1'b0; verify_in = 1'b0; en_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 4'hA;
      flt[i] = 4'h0;
    end
    tick(); tick();
    check_val("reset_outs", all_out(), 64'h0);
    check_val("reset_outs_b", {dat_b, addr_b, w_en_b, r_en_b, busy_b, done_b, err_b, err_addr_b, err_cnt_b}, 64'h0);
    rst = 1'b0;
    tick();
    check_val("idle_busy", busy_out, 1'b0);

    // 1: solid 0, no verify
    w0 = n_wr; wb0 = n_wr_bad; r0 = n_rd;
    en_in = 1'b1;
    wait_done(2000, cyc);
    check_val("t1_cycles", cyc, 257);
    check_val("t1_writes", n_wr - w0, 256);
    check_val("t1_wr_bad", n_wr_bad - wb0, 0);
    check_val("t1_reads", n_rd - r0, 0);
    check_val("t1_busy", busy_out, 1'b0);
    tick(); tick(); tick();
    check_val("t1_done_held", {rst_done, w_en_out, addr_out}, {1'b1, 1'b0, 8'h00});
    en_in = 1'b0;
    tick();
    check_val("t1_back_idle", rst_done, 1'b0);

    // 2: inverted checkerboard with verify, clean memory
    rev_in = 1'b1; chk_in = 1'b1; verify_in = 1'b1;
    w0 = n_wr; wb0 = n_wr_bad; r0 = n_rd;
    en_in = 1'b1;
    wait_done(2000, cyc);
    check_val("t2_cycles", cyc, 515);
    check_val("t2_reads", n_rd - r0, 256);
    check_val("t2_wr_bad", n_wr_bad - wb0, 0);
    check_val("t2_mem_even", {mem[0], mem[8'h80]}, 8'hFF);
    check_val("t2_mem_odd", {mem[1], mem[8'hFF]}, 8'h00);
    check_val("t2_err", {err_out, err_cnt_out}, 9'h0);
    check_val("t2_both_en", n_both, 0);
    en_in = 1'b0;
    tick();

    // 3: stuck-at-1 on bit 2 at 0x37 and 0xA0, solid 0
    rev_in = 1'b0; chk_in = 1'b0; verify_in = 1'b1;
    flt[8'h37] = 4'h4; flt[8'hA0] = 4'h4;
    en_in = 1'b1;
    wait_done(2000, cyc);
    check_val("t3_cycles", cyc, 515);
    check_val("t3_err", err_out, 1'b1);
    check_val("t3_err_addr", err_addr_out, 8'h37);
    check_val("t3_err_cnt", err_cnt_out, 8'd2);
    en_in = 1'b0;
    tick();

    // 4: saturating counter, every read corrupted
    en_b = 1'b1;
    cyc = 0;
    while (!done_b && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_val("t4_cycles", cyc, 514);
    check_val("t4_err_cnt", err_cnt_b, 2'd3);
    check_val("t4_err_addr", err_addr_b, 8'h00);
    check_val("t4_err", err_b, 1'b1);
    en_b = 1'b0;
    tick();

    // 5: abort during write at address 100, then rerun
    chk_in = 1'b1;
    en_in = 1'b1;
    tick();
    check_val("t5_start_clr", {err_out, err_addr_out, err_cnt_out}, 17'h0);
    check_val("t5_first_wr", {w_en_out, addr_out, dat_out}, {1'b1, 8'h00, 4'h0});
    tick();
    check_val("t5_second_wr", {addr_out, dat_out}, {8'h01, 4'hF});
    k = 0;
    while (addr_out != 8'd100 && k < 400) begin
      tick();
      k++;
    end
    check_val("t5_reach100", k < 400, 1'b1);
    en_in = 1'b0;
    tick();
    check_val("t5_abort", {w_en_out, r_en_out, busy_out, rst_done}, 4'b0000);
    tick(); tick();
    check_val("t5_no_done", rst_done, 1'b0);
    chk_in = 1'b0;
    en_in = 1'b1;
    tick();
    check_val("t5_restart", {w_en_out, addr_out}, {1'b1, 8'h00});
    wait_done(2000, cyc);
    check_val("t5_rerun_cycles", cyc + 1, 515);
    check_val("t5_rerun_cnt", {err_addr_out, err_cnt_out}, {8'h37, 8'd2});
    en_in = 1'b0;
    tick();

    // 6: reset mid-read with faulted reads still in flight
    flt[8'h37] = 4'h0; flt[8'hA0] = 4'h0;
    flt[48] = 4'h4; flt[49] = 4'h4; flt[50] = 4'h4;
    en_in = 1'b1;
    k = 0;
    while (!(r_en_out && addr_out == 8'd50) && k < 1000) begin
      tick();
      k++;
    end
    check_val("t6_reach50", k < 1000, 1'b1);
    check_val("t6_pre_err", err_out, 1'b0);
    rst = 1'b1;
    tick();
    check_val("t6_rst_outs", all_out(), 64'h0);
    rst = 1'b0;
    en_in = 1'b0;
    tick(); tick(); tick(); tick();
    check_val("t6_no_late", {err_out, err_cnt_out, busy_out}, 10'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
